// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared definitions for the video test-pattern generator:
//               pattern mode encodings, colour-bar palette, standard
//               720p/1080p timing sets and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

  // Pattern select encodings (matches the 2-bit mode input)
  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_GRID  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  // Colour-bar palette, one {r,g,b} full-scale flag per bar.
  // Index 0 is the left-most bar: white, yellow, cyan, green,
  // magenta, red, blue, black.
  localparam logic [7:0][2:0] PALETTE = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

  // 1280x720 @ 60 Hz timing set
  localparam int T720_H_ACTIVE  = 1280;
  localparam int T720_H_FP      = 110;
  localparam int T720_H_SYNC    = 40;
  localparam int T720_H_BP      = 220;
  localparam int T720_V_ACTIVE  = 720;
  localparam int T720_V_FP      = 5;
  localparam int T720_V_SYNC    = 5;
  localparam int T720_V_BP      = 20;

  // 1920x1080 @ 60 Hz timing set
  localparam int T1080_H_ACTIVE = 1920;
  localparam int T1080_H_FP     = 88;
  localparam int T1080_H_SYNC   = 44;
  localparam int T1080_H_BP     = 148;
  localparam int T1080_V_ACTIVE = 1080;
  localparam int T1080_V_FP     = 4;
  localparam int T1080_V_SYNC   = 5;
  localparam int T1080_V_BP     = 36;

  // Bits needed to count 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Horizontal/vertical raster counters with registered sync and
//               data-enable generation. Exposes the raw counter state plus
//               end-of-line and end-of-frame strobes for the pattern logic.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = T720_H_ACTIVE,
  parameter int H_FP     = T720_H_FP,
  parameter int H_SYNC   = T720_H_SYNC,
  parameter int H_BP     = T720_H_BP,
  parameter int V_ACTIVE = T720_V_ACTIVE,
  parameter int V_FP     = T720_V_FP,
  parameter int V_SYNC   = T720_V_SYNC,
  parameter int V_BP     = T720_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int HW       = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          h_end,
  output logic          eof,
  output logic          hs,
  output logic          vs,
  output logic          de
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START  = H_ACTIVE + H_FP;
  localparam int HS_END    = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START  = V_ACTIVE + V_FP;
  localparam int VS_END    = V_ACTIVE + V_FP + V_SYNC;

  // 32-bit views so boundary compares never overflow the counter width
  logic [31:0] hx;
  logic [31:0] vx;
  logic        v_last;
  logic        h_sync;
  logic        v_sync;
  logic        active;

  assign hx     = 32'(h_cnt);
  assign vx     = 32'(v_cnt);
  assign h_end  = (hx == H_TOTAL - 1);
  assign v_last = (vx == V_TOTAL - 1);
  assign eof    = h_end && v_last;
  assign h_sync = (hx >= HS_START) && (hx < HS_END);
  assign v_sync = (vx >= VS_START) && (vx < VS_END);
  assign active = (hx < H_ACTIVE) && (vx < V_ACTIVE);

  // Raster counters: h wraps every line, v advances on each h wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_end) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Syncs and data enable registered from the current counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs <= ~HS_POL;
      vs <= ~VS_POL;
      de <= 1'b0;
    end else begin
      hs <= h_sync ? HS_POL : ~HS_POL;
      vs <= v_sync ? VS_POL : ~VS_POL;
      de <= active;
    end
  end

endmodule
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_pattern_gen
// Description : Video test-pattern generator. Produces colour bars, a
//               horizontal gradient, a grid or a solid colour on a
//               parameterised raster. Mode and solid colour are shadowed at
//               the end of each frame so a frame never tears mid-way.
// Revision    : 1.0 - initial release
// ============================================================================
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = T720_H_ACTIVE,
  parameter int H_FP     = T720_H_FP,
  parameter int H_SYNC   = T720_H_SYNC,
  parameter int H_BP     = T720_H_BP,
  parameter int V_ACTIVE = T720_V_ACTIVE,
  parameter int V_FP     = T720_V_FP,
  parameter int V_SYNC   = T720_V_SYNC,
  parameter int V_BP     = T720_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int COLOR_W  = 8,
  parameter int NUM_BARS = 8,
  parameter int GRID     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] solid_r,
  input  logic [COLOR_W-1:0] solid_g,
  input  logic [COLOR_W-1:0] solid_b,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [COLOR_W-1:0] rgb_r,
  output logic [COLOR_W-1:0] rgb_g,
  output logic [COLOR_W-1:0] rgb_b,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);
  localparam int BW      = H_ACTIVE / NUM_BARS;  // elaboration-time constant
  localparam int BPW     = cnt_width(BW);
  localparam int GW      = cnt_width(GRID);

  logic [HW-1:0]      h_cnt;
  logic [VW-1:0]      v_cnt;
  logic               h_end;
  logic               eof;
  logic [31:0]        hx;
  logic [31:0]        vx;

  logic [BPW-1:0]     bar_pos;   // pixel offset inside the current bar
  logic [2:0]         bar_idx;   // current bar, saturates at NUM_BARS-1
  logic [GW-1:0]      gx;        // h_cnt mod GRID
  logic [GW-1:0]      gy;        // v_cnt mod GRID

  mode_e              mode_q;
  logic [COLOR_W-1:0] solid_r_q;
  logic [COLOR_W-1:0] solid_g_q;
  logic [COLOR_W-1:0] solid_b_q;

  logic               active;
  logic [2:0]         bar_bits;
  logic               grid_on;
  logic [COLOR_W-1:0] grad;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk   (clk),
    .rst_n (rst_n),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt),
    .h_end (h_end),
    .eof   (eof),
    .hs    (hs),
    .vs    (vs),
    .de    (de)
  );

  assign hx = 32'(h_cnt);
  assign vx = 32'(v_cnt);

  // Bar position tracks h_cnt: a BW-wide counter steps the bar index,
  // which saturates so any remainder pixels extend the last bar
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (h_end) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (hx < H_ACTIVE) begin
      if (bar_pos == BPW'(BW - 1)) begin
        bar_pos <= '0;
        if (bar_idx != 3'(NUM_BARS - 1)) begin
          bar_idx <= bar_idx + 1'b1;
        end
      end else begin
        bar_pos <= bar_pos + 1'b1;
      end
    end
  end

  // Grid phase counters: wrap at GRID and realign at line / frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx <= '0;
      gy <= '0;
    end else if (h_end) begin
      gx <= '0;
      if (eof) begin
        gy <= '0;
      end else begin
        gy <= (gy == GW'(GRID - 1)) ? '0 : gy + 1'b1;
      end
    end else begin
      gx <= (gx == GW'(GRID - 1)) ? '0 : gx + 1'b1;
    end
  end

  // Shadow registers load only on the last clock of a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_BARS;
      solid_r_q <= '0;
      solid_g_q <= '0;
      solid_b_q <= '0;
    end else if (eof) begin
      mode_q    <= mode_e'(mode);
      solid_r_q <= solid_r;
      solid_g_q <= solid_g;
      solid_b_q <= solid_b;
    end
  end

  // Pixel colour for the current counter position; black in blanking
  always_comb begin
    pix_r    = '0;
    pix_g    = '0;
    pix_b    = '0;
    bar_bits = PALETTE[bar_idx];
    grid_on  = (gx == '0) || (gy == '0) ||
               (hx == H_ACTIVE - 1) || (vx == V_ACTIVE - 1);
    grad     = COLOR_W'(h_cnt);
    active   = (hx < H_ACTIVE) && (vx < V_ACTIVE);
    if (active) begin
      case (mode_q)
        MODE_BARS: begin
          pix_r = {COLOR_W{bar_bits[2]}};
          pix_g = {COLOR_W{bar_bits[1]}};
          pix_b = {COLOR_W{bar_bits[0]}};
        end
        MODE_GRAD: begin
          pix_r = grad;
          pix_g = grad;
          pix_b = grad;
        end
        MODE_GRID: begin
          pix_r = {COLOR_W{grid_on}};
          pix_g = {COLOR_W{grid_on}};
          pix_b = {COLOR_W{grid_on}};
        end
        MODE_SOLID: begin
          pix_r = solid_r_q;
          pix_g = solid_g_q;
          pix_b = solid_b_q;
        end
        default: begin
          pix_r = '0;
          pix_g = '0;
          pix_b = '0;
        end
      endcase
    end
  end

  // Pixel data and frame marker registered alongside hs/vs/de
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_r       <= '0;
      rgb_g       <= '0;
      rgb_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      rgb_r       <= pix_r;
      rgb_g       <= pix_g;
      rgb_b       <= pix_b;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_video_pattern_gen
// Description : Self-checking bench for video_pattern_gen on a small raster,
//               with a frame-level reference model and a second instance
//               exercising gradient wrap at COLOR_W=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_pattern_gen;

  localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VSY = 2, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FRAME = HT * VT;
  localparam int CW = 8, NB = 4, GR = 4;
  localparam bit HP = 1'b0, VP = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [CW-1:0] sr = '0, sg = '0, sb = '0;
  logic          hs, vs, de, fs;
  logic [CW-1:0] rr, rg, rb;

  logic          hs2, vs2, de2, fs2;
  logic [3:0]    r2, g2, b2;
  logic [1:0]    mode2 = 2'd1;
  logic [3:0]    z4 = 4'd0;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .COLOR_W(CW), .NUM_BARS(NB), .GRID(GR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .solid_r(sr), .solid_g(sg), .solid_b(sb),
    .hs(hs), .vs(vs), .de(de),
    .rgb_r(rr), .rgb_g(rg), .rgb_b(rb), .frame_start(fs)
  );

  video_pattern_gen #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .NUM_BARS(4), .GRID(4)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .mode(mode2),
    .solid_r(z4), .solid_g(z4), .solid_b(z4),
    .hs(hs2), .vs(vs2), .de(de2),
    .rgb_r(r2), .rgb_g(g2), .rgb_b(b2), .frame_start(fs2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0] PAL [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] model_rgb(input int x, input int y,
                                            input logic [1:0] md, input logic [23:0] sol);
    int bi;
    logic [7:0] gv;
    if (!(x < HA && y < VA)) return 24'h0;
    case (md)
      2'd0: begin
        bi = x / (HA / NB);
        if (bi > NB - 1) bi = NB - 1;
        return PAL[bi];
      end
      2'd1: begin
        gv = 8'(x % 256);
        return {gv, gv, gv};
      end
      2'd2: return ((x % GR == 0) || (y % GR == 0) || (x == HA - 1) || (y == VA - 1))
                   ? 24'hFFFFFF : 24'h0;
      default: return sol;
    endcase
  endfunction

  int          cur = 0;     // pixel the DUT counters point at
  int          edges = 0;   // rising edges since last reset release
  logic [1:0]  m_mode = 2'd0;
  logic [23:0] m_solid = 24'h0;
  logic        e_hs = ~HP, e_vs = ~VP, e_de = 1'b0, e_fs = 1'b0;
  logic [23:0] e_rgb = 24'h0;

  initial begin : model
    int x, y;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cur = 0; edges = 0; m_mode = 2'd0; m_solid = 24'h0;
        e_hs = ~HP; e_vs = ~VP; e_de = 1'b0; e_fs = 1'b0; e_rgb = 24'h0;
      end else begin
        x = cur % HT;
        y = cur / HT;
        e_de  = (x < HA) && (y < VA);
        e_hs  = (x >= HA + HF && x < HA + HF + HSY) ? HP : ~HP;
        e_vs  = (y >= VA + VF && y < VA + VF + VSY) ? VP : ~VP;
        e_fs  = (cur == 0);
        e_rgb = model_rgb(x, y, m_mode, m_solid);
        if (cur == FRAME - 1) begin
          m_mode  = mode;
          m_solid = {sr, sg, sb};
        end
        cur = (cur + 1) % FRAME;
        edges++;
      end
    end
  end

  bit cmp_en = 1'b0;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (cmp_en)
        check($sformatf("pixel_e%0d", edges), {hs, vs, de, fs, rr, rg, rb},
              {e_hs, e_vs, e_de, e_fs, e_rgb});
    end
  end

  // Wait for the falling edge that follows rising edge k
  task automatic wait_edge(input int k);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (edges < k && guard < 5000);
    check($sformatf("reach_edge%0d", k), 64'(edges), 64'(k));
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int guard;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_hs", hs, 1'b1);
    check("rst_vs", vs, 1'b1);
    check("rst_de", de, 1'b0);
    check("rst_fs", fs, 1'b0);
    check("rst_rgb", {rr, rg, rb}, 24'h0);

    @(negedge clk); rst_n = 1'b1;
    wait_edge(1);
    check("first_fs", fs, 1'b1);
    check("first_de", de, 1'b1);
    check("bar_white", {rr, rg, rb}, 24'hFFFFFF);
    wait_edge(5);  check("bar_yellow", {rr, rg, rb}, 24'hFFFF00);
    wait_edge(9);  check("bar_cyan",   {rr, rg, rb}, 24'h00FFFF);
    wait_edge(13); check("bar_green",  {rr, rg, rb}, 24'h00FF00);
    wait_edge(16); check("bar_green_x15", {rr, rg, rb}, 24'h00FF00);
    wait_edge(17); check("blank_rgb", {rr, rg, rb}, 24'h0);
    check("blank_de", de, 1'b0);
    wait_edge(18); check("hs_before", hs, 1'b1);
    wait_edge(19); check("hs_first", hs, 1'b0);
    wait_edge(21); check("hs_last", hs, 1'b0);
    wait_edge(22); check("hs_after", hs, 1'b1);
    mode = 2'd2;  // mid-frame: grid must appear only next frame
    wait_edge(8 * HT + 24); check("vs_before", vs, 1'b1);
    wait_edge(9 * HT + 1);  check("vs_first", vs, 1'b0);
    wait_edge(11 * HT);     check("vs_last", vs, 1'b0);
    wait_edge(11 * HT + 1); check("vs_after", vs, 1'b1);
    wait_edge(FRAME);       check("fs_gap", fs, 1'b0);
    wait_edge(FRAME + 1);   check("fs_289", fs, 1'b1);
    check("grid_00", {rr, rg, rb}, 24'hFFFFFF);
    wait_edge(FRAME + 1 + 25); check("grid_11_black", {rr, rg, rb}, 24'h0);
    wait_edge(FRAME + 1 + 28); check("grid_41_white", {rr, rg, rb}, 24'hFFFFFF);
    wait_edge(FRAME + 1 + 39); check("grid_x15_white", {rr, rg, rb}, 24'hFFFFFF);
    wait_edge(FRAME + 1 + 97); check("grid_y4_white", {rr, rg, rb}, 24'hFFFFFF);
    mode = 2'd0;
    wait_edge(2 * FRAME + 1 + 100);
    mode = 2'd3; {sr, sg, sb} = 24'h123456;
    wait_edge(2 * FRAME + 1 + 121); check("no_tear_bars", {rr, rg, rb}, 24'hFFFFFF);
    wait_edge(3 * FRAME + 1); check("solid_next_frame", {rr, rg, rb}, 24'h123456);
    mode = 2'd1;
    wait_edge(4 * FRAME + 1 + 10); check("grad_x10", {rr, rg, rb}, 24'h0A0A0A);

    // Randomised mode/colour changes, checked each cycle by the model
    for (int i = 0; i < 10 * FRAME; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        mode = 2'($urandom_range(0, 3));
        sr = CW'($urandom); sg = CW'($urandom); sb = CW'($urandom);
      end
    end

    // Asynchronous reset with counters at h=10, v=3
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cur != 3 * HT + 10 && guard < 2 * FRAME);
    check("reach_h10_v3", 64'(cur), 64'(3 * HT + 10));
    check("pre_reset_de", de, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_hs", hs, 1'b1);
    check("async_vs", vs, 1'b1);
    check("async_de", de, 1'b0);
    check("async_fs", fs, 1'b0);
    check("async_rgb", {rr, rg, rb}, 24'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_edge(1);
    check("restart_fs", fs, 1'b1);
    check("restart_de", de, 1'b1);
    check("restart_white", {rr, rg, rb}, 24'hFFFFFF);

    // Second instance: gradient with COLOR_W=4 wraps at x=16
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (fs2 !== 1'b1 && guard < 400);
    check("dut2_fs", fs2, 1'b1);
    check("dut2_x0", {r2, g2, b2}, 12'h000);
    repeat (15) @(negedge clk);
    check("dut2_x15", {r2, g2, b2}, 12'hFFF);
    @(negedge clk);
    check("dut2_x16_wrap", {r2, g2, b2}, 12'h000);
    check("dut2_x16_de", de2, 1'b1);
    repeat (3) @(negedge clk);
    check("dut2_x19", {r2, g2, b2}, 12'h333);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
